mem_arbiter: RTL and testbench

//   Two-requester arbiter and sequencer for the 4x8 single-port block RAM (mem).

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port block RAM: grants one
// request at a time, drives the RAM strobes and returns per-port done/rdata.
module mem_arbiter #(
  parameter int AW         = 2,
  parameter int DW         = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_done,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_done,
  output logic [DW-1:0] b_rdata,
  output logic          busy,
  output logic          mem_ce,
  output logic          mem_oce,
  output logic          mem_wre,
  output logic          mem_reset,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [1:0]    r_state;
  logic          r_owner_b;
  logic          r_last_b;
  logic          r_mem_ce;
  logic          r_mem_wre;
  logic [AW-1:0] r_mem_ad;
  logic [DW-1:0] r_mem_din;
  logic          r_a_done;
  logic          r_b_done;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;

  logic w_can_grant;
  logic w_pick_b;
  logic w_a_gnt;
  logic w_b_gnt;

  // B wins when it is alone, or on a tie in round-robin mode when A went last.
  assign w_can_grant = (r_state == S_IDLE) && !reset;
  assign w_pick_b    = b_req && (!a_req || ((FIXED_PRIO == 0) && !r_last_b));
  assign w_a_gnt     = w_can_grant && a_req && !w_pick_b;
  assign w_b_gnt     = w_can_grant && w_pick_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner_b <= 1'b0;
      r_last_b  <= 1'b1;
      r_mem_ce  <= 1'b0;
      r_mem_wre <= 1'b0;
      r_mem_ad  <= '0;
      r_mem_din <= '0;
      r_a_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_a_rdata <= '0;
      r_b_rdata <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register samples pre-edge values.
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_a_gnt || w_b_gnt) begin
            r_mem_ce  <= 1'b1;
            r_mem_wre <= w_b_gnt ? b_we    : a_we;
            r_mem_ad  <= w_b_gnt ? b_addr  : a_addr;
            r_mem_din <= w_b_gnt ? b_wdata : a_wdata;
            r_owner_b <= w_b_gnt;
            r_last_b  <= w_b_gnt;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_mem_ce  <= 1'b0;
          r_mem_wre <= 1'b0;
          if (r_mem_wre) begin
            r_a_done <= !r_owner_b;
            r_b_done <= r_owner_b;
            r_state  <= S_IDLE;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // RAM output register now holds the word read on the previous edge.
          if (r_owner_b) begin
            r_b_rdata <= mem_dout;
            r_b_done  <= 1'b1;
          end else begin
            r_a_rdata <= mem_dout;
            r_a_done  <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_gnt     = w_a_gnt;
  assign b_gnt     = w_b_gnt;
  assign a_done    = r_a_done;
  assign b_done    = r_b_done;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign busy      = (r_state != S_IDLE);
  assign mem_ce    = r_mem_ce;
  assign mem_oce   = 1'b1;
  assign mem_wre   = r_mem_wre;
  assign mem_reset = reset;
  assign mem_ad    = r_mem_ad;
  assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [1:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       a_gnt, a_done, b_gnt, b_done, busy;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_ce, mem_oce, mem_wre, mem_reset;
  logic [1:0] mem_ad;
  logic [7:0] mem_din, mem_dout;

  logic       p_a_gnt, p_a_done, p_b_gnt, p_b_done, p_busy;
  logic [7:0] p_a_rdata, p_b_rdata;
  logic       p_mem_ce, p_mem_oce, p_mem_wre, p_mem_reset;
  logic [1:0] p_mem_ad;
  logic [7:0] p_mem_din;
  logic [7:0] p_mem_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(2), .DW(8), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
    .busy(busy), .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre),
    .mem_reset(mem_reset), .mem_ad(mem_ad), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_arbiter #(.AW(2), .DW(8), .FIXED_PRIO(1)) dut_prio (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(p_a_gnt), .a_done(p_a_done), .a_rdata(p_a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(p_b_gnt), .b_done(p_b_done), .b_rdata(p_b_rdata),
    .busy(p_busy), .mem_ce(p_mem_ce), .mem_oce(p_mem_oce), .mem_wre(p_mem_wre),
    .mem_reset(p_mem_reset), .mem_ad(p_mem_ad), .mem_din(p_mem_din), .mem_dout(p_mem_dout)
  );

  // Behavioural 4x8 RAM with registered read output.
  logic [7:0] ram [4];
  always @(posedge clk or posedge mem_reset) begin
    if (mem_reset) mem_dout <= '0;
    else if (mem_ce) begin
      if (mem_wre) ram[mem_ad] <= mem_din;
      else         mem_dout    <= ram[mem_ad];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction-level view (who is granted, when it ends, what it returns).
  int         c = 0;
  int         next_free, due, acc_c;
  bit         due_b, pend_is_read, acc_we, last_b;
  logic [1:0] acc_addr;
  logic [7:0] acc_data, pend_data, ref_a_rd, ref_b_rd;
  logic [7:0] ref_mem [4];
  bit         ga_now = 0, gb_now = 0, da_now = 0, db_now = 0;
  int         ga_c, gb_c, da_c, db_c;
  int         p_ga_cnt, p_gb_cnt;

  task automatic reset_model();
    next_free    = c;
    due          = -1;
    acc_c        = -1;
    due_b        = 0;
    pend_is_read = 0;
    last_b       = 1;
    ref_a_rd     = '0;
    ref_b_rd     = '0;
  endtask

  // Called at a falling edge with inputs already set; checks this cycle, then advances one clock.
  task automatic tick();
    bit         ea, eb, free, we;
    logic [1:0] addr;
    logic [7:0] data;
    #2;
    free = (c >= next_free);
    ea = 0;
    eb = 0;
    if (free) begin
      if (a_req && b_req) begin
        if (last_b) ea = 1; else eb = 1;
      end else if (a_req) ea = 1;
      else if (b_req)     eb = 1;
    end
    if (c == due && pend_is_read) begin
      if (due_b) ref_b_rd = pend_data; else ref_a_rd = pend_data;
    end
    check("a_gnt",   a_gnt,   ea);
    check("b_gnt",   b_gnt,   eb);
    check("busy",    busy,    !free);
    check("a_done",  a_done,  (c == due) && !due_b);
    check("b_done",  b_done,  (c == due) && due_b);
    check("a_rdata", a_rdata, ref_a_rd);
    check("b_rdata", b_rdata, ref_b_rd);
    check("mem_ce",  mem_ce,  c == acc_c);
    if (c == acc_c) begin
      check("mem_wre", mem_wre, acc_we);
      check("mem_ad",  mem_ad,  acc_addr);
      if (acc_we) check("mem_din", mem_din, acc_data);
    end
    if (ea || eb) begin
      we   = ea ? a_we    : b_we;
      addr = ea ? a_addr  : b_addr;
      data = ea ? a_wdata : b_wdata;
      acc_c    = c + 1;
      acc_we   = we;
      acc_addr = addr;
      acc_data = data;
      pend_is_read = !we;
      due       = c + (we ? 2 : 3);
      due_b     = eb;
      next_free = due;
      last_b    = eb;
      if (we) ref_mem[addr] = data;
      else    pend_data     = ref_mem[addr];
    end
    ga_now = a_gnt;
    gb_now = b_gnt;
    da_now = a_done;
    db_now = b_done;
    if (a_gnt)   ga_c = c;
    if (b_gnt)   gb_c = c;
    if (a_done)  da_c = c;
    if (b_done)  db_c = c;
    if (p_a_gnt) p_ga_cnt++;
    if (p_b_gnt) p_gb_cnt++;
    @(negedge clk);
    c++;
  endtask

  task automatic do_reset();
    reset = 1;
    a_req = 0;
    b_req = 0;
    #1;
    check("rst_busy",      busy,      0);
    check("rst_mem_ce",    mem_ce,    0);
    check("rst_mem_wre",   mem_wre,   0);
    check("rst_mem_ad",    mem_ad,    0);
    check("rst_mem_din",   mem_din,   0);
    check("rst_a_done",    a_done,    0);
    check("rst_b_done",    b_done,    0);
    check("rst_a_rdata",   a_rdata,   0);
    check("rst_b_rdata",   b_rdata,   0);
    check("rst_a_gnt",     a_gnt,     0);
    check("rst_mem_reset", mem_reset, 1);
    check("rst_mem_oce",   mem_oce,   1);
    check("rst_p_mem_oce", p_mem_oce, 1);
    repeat (2) @(negedge clk);
    reset = 0;
    reset_model();
  endtask

  // One complete access on a port: raise req, wait for gnt, drop req, wait for done.
  task automatic access(input bit port_b, input logic we, input logic [1:0] addr,
                        input logic [7:0] data);
    bit got;
    if (port_b) begin
      b_req = 1; b_we = we; b_addr = addr; b_wdata = data;
    end else begin
      a_req = 1; a_we = we; a_addr = addr; a_wdata = data;
    end
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      tick();
      got = port_b ? gb_now : ga_now;
    end
    check("gnt_wait", got, 1);
    if (port_b) b_req = 0; else a_req = 0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = port_b ? db_now : da_now;
    end
    check("done_wait", got, 1);
  endtask

  initial begin
    int         order [4];
    int         n;
    bit         got;
    logic [1:0] wa;

    reset = 1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    p_mem_dout = '0;
    for (int i = 0; i < 4; i++) begin
      ram[i]     = '0;
      ref_mem[i] = '0;
    end

    // Write then read back on A, with latency checks.
    do_reset();
    access(0, 1, 2'd2, 8'h5A);
    check("t1_wr_latency", da_c - ga_c, 2);
    access(0, 0, 2'd2, 8'h00);
    check("t1_rd_latency", da_c - ga_c, 3);
    check("t1_rdata", a_rdata, 8'h5A);

    // Both ports read continuously: round-robin in dut, A always wins in dut_prio.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 2'd0;
    b_req = 1; b_we = 0; b_addr = 2'd1;
    p_ga_cnt = 0;
    p_gb_cnt = 0;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      tick();
      if (ga_now)      begin order[n] = 0; n++; end
      else if (gb_now) begin order[n] = 1; n++; end
    end
    a_req = 0;
    b_req = 0;
    repeat (4) tick();
    check("t2_rounds", n, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t2_rr_order%0d", i), order[i], i % 2);
    check("t2_prio_a_grants", p_ga_cnt, 4);
    check("t2_prio_b_grants", p_gb_cnt, 0);

    // Fill through B, read back through A; B's read data must not move.
    for (int i = 0; i < 4; i++) access(1, 1, 2'(i), 8'((i + 1) * 8'h11));
    access(1, 0, 2'd1, 8'h00);
    check("t3_b_rdata", b_rdata, 8'h22);
    for (int i = 0; i < 4; i++) begin
      access(0, 0, 2'(i), 8'h00);
      check($sformatf("t3_a_rdata%0d", i), a_rdata, 8'((i + 1) * 8'h11));
      check($sformatf("t3_b_held%0d", i), b_rdata, 8'h22);
    end
    wa = 2'd3;
    wa = wa + 2'd1;
    access(0, 0, wa, 8'h00);
    check("t3_wrap", a_rdata, 8'h11);

    // A writes, B's read of the same word is granted on A's done cycle.
    a_req = 1; a_we = 1; a_addr = 2'd1; a_wdata = 8'hC3;
    tick();
    check("t4_a_gnt", ga_now, 1);
    a_req = 0;
    b_req = 1; b_we = 0; b_addr = 2'd1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin tick(); got = gb_now; end
    check("t4_b_gnt_wait", got, 1);
    b_req = 0;
    check("t4_b_gnt_on_done", gb_c, da_c);
    check("t4_b_gnt_cycle", gb_c - ga_c, 2);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin tick(); got = db_now; end
    check("t4_b_done_wait", got, 1);
    check("t4_b_rdata", b_rdata, 8'hC3);

    // Reset during ACCESS of a read: abandoned without done.
    a_req = 1; a_we = 0; a_addr = 2'd2;
    tick();
    check("t5_a_gnt", ga_now, 1);
    a_req = 0;
    #2;
    check("t5_ce_before", mem_ce, 1);
    reset = 1;
    #1;
    check("t5_ce_dropped", mem_ce, 0);
    check("t5_busy_dropped", busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      c++;
      check("t5_no_done", a_done, 0);
    end
    reset = 0;
    reset_model();
    access(0, 0, 2'd3, 8'h00);
    check("t5_post_latency", da_c - ga_c, 3);
    check("t5_post_rdata", a_rdata, 8'h44);

    // Randomized traffic, including withdrawn requests.
    ga_now = 0;
    gb_now = 0;
    for (int i = 0; i < 10000; i++) begin
      if (ga_now) a_req = 0;
      else if (a_req && $urandom_range(19) == 0) a_req = 0;
      else if (!a_req && $urandom_range(2) == 0) begin
        a_req = 1; a_we = 1'($urandom_range(1));
        a_addr = 2'($urandom); a_wdata = 8'($urandom);
      end
      if (gb_now) b_req = 0;
      else if (b_req && $urandom_range(19) == 0) b_req = 0;
      else if (!b_req && $urandom_range(2) == 0) begin
        b_req = 1; b_we = 1'($urandom_range(1));
        b_addr = 2'($urandom); b_wdata = 8'($urandom);
      end
      tick();
    end
    a_req = 0;
    b_req = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
